// File: rtl/sd_rx_pktfilt_pkg.sv
// Shared types and helpers for the store-and-forward RX packet filter.
// Packet codes mirror the bridge-wide packet-code values.
package sd_rx_pktfilt_pkg;

    localparam logic [1:0] PCC_DATA   = 2'b00;
    localparam logic [1:0] PCC_SOP    = 2'b01;
    localparam logic [1:0] PCC_EOP    = 2'b10;
    localparam logic [1:0] PCC_BADEOP = 2'b11;

    localparam int PKT_WORD_W = 10;

    typedef enum logic [1:0] {
        s_idle = 2'd0,
        s_pkt  = 2'd1,
        s_drop = 2'd2
    } wr_state_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/sd_rx_pktfilt_mem.sv
// Simple dual-port memory: one write port, one read port with registered address.
// rd_data reflects the array at the address captured on the previous edge.
module behave2p_mem
    import sd_rx_pktfilt_pkg::*;
#(
    parameter int width   = PKT_WORD_W,
    parameter int addr_sz = 9,
    parameter int depth   = 2**addr_sz
) (
    input  logic               clk,
    input  logic               wr_en,
    input  logic [addr_sz-1:0] wr_addr,
    input  logic [width-1:0]   wr_data,
    input  logic [addr_sz-1:0] rd_addr,
    output logic [width-1:0]   rd_data
);

    logic [width-1:0]   mem_q [depth];
    logic [addr_sz-1:0] rd_addr_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
        rd_addr_q <= rd_addr;
    end

    assign rd_data = mem_q[rd_addr_q];

endmodule

// File: rtl/sd_rx_pktfilt.sv
// Store-and-forward packet filter: buffers each MAC packet and releases it
// downstream only once a good EOP commits it; bad/overflowed/cut packets are dropped.
module sd_rx_pktfilt
    import sd_rx_pktfilt_pkg::*;
#(
    parameter int asz = 9
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        c_srdy,
    output logic        c_drdy,
    input  logic [1:0]  c_code,
    input  logic [7:0]  c_data,
    output logic        p_srdy,
    input  logic        p_drdy,
    output logic [1:0]  p_code,
    output logic [7:0]  p_data,
    output logic [15:0] drop_count
);

    localparam int         DEPTH   = 2**asz;
    localparam logic [asz:0] DEPTH_V = {1'b1, {asz{1'b0}}};

    wr_state_e       state_q, state_d;
    logic [asz:0]    wr_ptr_q, wr_ptr_d;
    logic [asz:0]    com_ptr_q, com_ptr_d;
    logic [asz:0]    rd_ptr_q, rd_ptr_d;
    logic [15:0]     drop_count_q, drop_count_d;
    logic            c_drdy_q, c_drdy_d;
    logic            p_srdy_q, p_srdy_d;
    logic [1:0]      p_code_q, p_code_d;
    logic [7:0]      p_data_q, p_data_d;

    logic            xfer;
    logic            full;
    logic            com_full;
    logic            drop;
    logic            wr_en;
    logic [asz-1:0]  wr_addr;
    logic [9:0]      wr_word;
    logic [9:0]      rd_word;
    logic            load;

    assign xfer     = c_srdy & c_drdy_q;
    assign full     = (wr_ptr_q - rd_ptr_q) == DEPTH_V;
    assign com_full = (com_ptr_q - rd_ptr_q) == DEPTH_V;
    assign wr_word  = {c_code, c_data};

    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        com_ptr_d = com_ptr_q;
        wr_en     = 1'b0;
        wr_addr   = wr_ptr_q[asz-1:0];
        drop      = 1'b0;
        c_drdy_d  = 1'b1;

        if (xfer) begin
            case (state_q)
                s_idle, s_drop: begin
                    if (c_code == PCC_SOP) begin
                        if (!full) begin
                            wr_en    = 1'b1;
                            wr_ptr_d = wr_ptr_q + 1'b1;
                            state_d  = s_pkt;
                        end else begin
                            drop    = 1'b1;
                            state_d = s_drop;
                        end
                    end else if (state_q == s_drop && c_code != PCC_DATA) begin
                        state_d = s_idle;
                    end
                end
                s_pkt: begin
                    case (c_code)
                        PCC_DATA: begin
                            if (!full) begin
                                wr_en    = 1'b1;
                                wr_ptr_d = wr_ptr_q + 1'b1;
                            end else begin
                                wr_ptr_d = com_ptr_q;
                                drop     = 1'b1;
                                state_d  = s_drop;
                            end
                        end
                        PCC_EOP: begin
                            if (!full) begin
                                wr_en     = 1'b1;
                                wr_ptr_d  = wr_ptr_q + 1'b1;
                                com_ptr_d = wr_ptr_q + 1'b1;
                            end else begin
                                wr_ptr_d = com_ptr_q;
                                drop     = 1'b1;
                            end
                            state_d = s_idle;
                        end
                        PCC_BADEOP: begin
                            wr_ptr_d = com_ptr_q;
                            drop     = 1'b1;
                            state_d  = s_idle;
                        end
                        default: begin
                            // Premature SOP: abandon the open packet and restart at the commit point.
                            // If committed data already fills the buffer the new packet cannot start.
                            drop = 1'b1;
                            if (!com_full) begin
                                wr_en    = 1'b1;
                                wr_addr  = com_ptr_q[asz-1:0];
                                wr_ptr_d = com_ptr_q + 1'b1;
                            end else begin
                                wr_ptr_d = com_ptr_q;
                                state_d  = s_drop;
                            end
                        end
                    endcase
                end
                default: state_d = s_idle;
            endcase
        end

        drop_count_d = drop ? sat_inc16(drop_count_q) : drop_count_q;
    end

    always_comb begin
        load     = (!p_srdy_q || p_drdy) && (rd_ptr_q != com_ptr_q);
        rd_ptr_d = rd_ptr_q;
        p_srdy_d = p_srdy_q;
        p_code_d = p_code_q;
        p_data_d = p_data_q;
        if (load) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            p_srdy_d = 1'b1;
            p_code_d = rd_word[9:8];
            p_data_d = rd_word[7:0];
        end else if (p_drdy) begin
            p_srdy_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= s_idle;
            wr_ptr_q     <= '0;
            com_ptr_q    <= '0;
            rd_ptr_q     <= '0;
            drop_count_q <= '0;
            c_drdy_q     <= 1'b0;
            p_srdy_q     <= 1'b0;
            p_code_q     <= '0;
            p_data_q     <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            com_ptr_q    <= com_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            drop_count_q <= drop_count_d;
            c_drdy_q     <= c_drdy_d;
            p_srdy_q     <= p_srdy_d;
            p_code_q     <= p_code_d;
            p_data_q     <= p_data_d;
        end
    end

    // Address is fed from rd_ptr_d so the memory output always shows mem[rd_ptr_q].
    behave2p_mem #(
        .width   (PKT_WORD_W),
        .addr_sz (asz),
        .depth   (DEPTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_word),
        .rd_addr (rd_ptr_d[asz-1:0]),
        .rd_data (rd_word)
    );

    assign c_drdy     = c_drdy_q;
    assign p_srdy     = p_srdy_q;
    assign p_code     = p_code_q;
    assign p_data     = p_data_q;
    assign drop_count = drop_count_q;

endmodule

// File: tb/tb_sd_rx_pktfilt.sv
// Directed bench for sd_rx_pktfilt with asz=4 (16-word buffer).
module tb_sd_rx_pktfilt;

    localparam logic [1:0] C_DATA   = 2'b00;
    localparam logic [1:0] C_SOP    = 2'b01;
    localparam logic [1:0] C_EOP    = 2'b10;
    localparam logic [1:0] C_BADEOP = 2'b11;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        c_srdy = 1'b0;
    logic        c_drdy;
    logic [1:0]  c_code = 2'b00;
    logic [7:0]  c_data = 8'h00;
    logic        p_srdy;
    logic        p_drdy;
    logic [1:0]  p_code;
    logic [7:0]  p_data;
    logic [15:0] drop_count;

    logic        p_drdy_fix = 1'b1;
    logic        alt_mode = 1'b0;
    logic        alt_tog = 1'b0;

    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    logic [9:0]  cap_q[$];
    int          cap_cyc[$];
    logic [9:0]  exp_q[$];

    assign p_drdy = alt_mode ? alt_tog : p_drdy_fix;

    sd_rx_pktfilt #(.asz(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .c_srdy     (c_srdy),
        .c_drdy     (c_drdy),
        .c_code     (c_code),
        .c_data     (c_data),
        .p_srdy     (p_srdy),
        .p_drdy     (p_drdy),
        .p_code     (p_code),
        .p_data     (p_data),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) alt_tog <= ~alt_tog;

    always @(posedge clk) begin
        cyc++;
        if (!reset && p_srdy && p_drdy) begin
            cap_q.push_back({p_code, p_data});
            cap_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [1:0] code, input logic [7:0] data);
        c_srdy = 1'b1;
        c_code = code;
        c_data = data;
        @(negedge clk);
        c_srdy = 1'b0;
    endtask

    task automatic send_pkt(input logic [7:0] base, input int n, input logic [1:0] last, input bit keep);
        logic [1:0] code;
        logic [7:0] d;
        for (int i = 0; i < n; i++) begin
            code = (i == 0) ? C_SOP : ((i == n - 1) ? last : C_DATA);
            d = base + 8'(i);
            send(code, d);
            if (keep) exp_q.push_back({code, d});
        end
    endtask

    task automatic check_out(input string tag);
        int n;
        check({tag, "_len"}, cap_q.size(), exp_q.size());
        n = (cap_q.size() < exp_q.size()) ? cap_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_w%0d", tag, i), cap_q[i], exp_q[i]);
        end
        cap_q.delete();
        cap_cyc.delete();
        exp_q.delete();
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_c_drdy", c_drdy, 0);
        check("rst_p_srdy", p_srdy, 0);
        check("rst_p_code", p_code, 0);
        check("rst_p_data", p_data, 0);
        check("rst_drop", drop_count, 0);
        reset = 1'b0;
        #1;
        check("c_drdy_pre_edge", c_drdy, 0);
        @(negedge clk);
        check("c_drdy_up", c_drdy, 1);

        // good packet and its latency
        send_pkt(8'hA0, 5, C_EOP, 1);
        check("lat_after_n", p_srdy, 0);
        @(negedge clk);
        check("lat_after_n1", p_srdy, 1);
        check("lat_first_word", {p_code, p_data}, 10'h1A0);
        repeat (8) @(negedge clk);
        check_out("good");
        check("good_drop", drop_count, 0);

        // bad CRC then good packet
        send_pkt(8'h10, 5, C_BADEOP, 0);
        send_pkt(8'hA0, 5, C_EOP, 1);
        repeat (10) @(negedge clk);
        check_out("badcrc");
        check("badcrc_drop", drop_count, 1);

        // overflow under back-pressure
        p_drdy_fix = 1'b0;
        send(C_SOP, 8'h20);
        for (int i = 1; i < 16; i++) send(C_DATA, 8'h20 + 8'(i));
        check("ovf_drop_16", drop_count, 1);
        send(C_EOP, 8'h30);
        check("ovf_drop_17", drop_count, 2);
        send_pkt(8'hC0, 16, C_EOP, 1);
        repeat (3) @(negedge clk);
        check("ovf_hold_srdy", p_srdy, 1);
        check("ovf_hold_a", {p_code, p_data}, 10'h1C0);
        repeat (3) @(negedge clk);
        check("ovf_hold_b", {p_code, p_data}, 10'h1C0);
        p_drdy_fix = 1'b1;
        repeat (20) @(negedge clk);
        check_out("ovf");
        check("ovf_drop", drop_count, 2);

        // premature SOP
        send(C_SOP, 8'h10);
        send(C_DATA, 8'h11);
        send_pkt(8'hB0, 3, C_EOP, 1);
        repeat (8) @(negedge clk);
        check_out("presop");
        check("presop_drop", drop_count, 3);

        // alternating back-pressure
        alt_mode = 1'b1;
        send_pkt(8'hD0, 4, C_EOP, 1);
        send_pkt(8'hE0, 4, C_EOP, 1);
        repeat (30) @(negedge clk);
        alt_mode = 1'b0;
        check_out("alt");

        // full-rate delivery
        send_pkt(8'h50, 4, C_EOP, 1);
        send_pkt(8'h60, 4, C_EOP, 1);
        repeat (15) @(negedge clk);
        check("thru_span", (cap_cyc.size() == 8) ? (cap_cyc[7] - cap_cyc[0]) : -1, 7);
        check_out("thru");
        check("thru_drop", drop_count, 3);

        // async reset while a packet is waiting at the output
        p_drdy_fix = 1'b0;
        send_pkt(8'h70, 4, C_EOP, 0);
        repeat (3) @(negedge clk);
        check("pre_rst_srdy", p_srdy, 1);
        #2 reset = 1'b1;
        #1;
        check("async_p_srdy", p_srdy, 0);
        check("async_drop", drop_count, 0);
        check("async_c_drdy", c_drdy, 0);
        @(negedge clk);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        cap_q.delete();
        cap_cyc.delete();
        p_drdy_fix = 1'b1;
        @(negedge clk);
        send(C_DATA, 8'h55);
        send(C_DATA, 8'h66);
        send(C_EOP, 8'h77);
        repeat (6) @(negedge clk);
        check("orphan_srdy", p_srdy, 0);
        check_out("orphan");
        send_pkt(8'hF0, 3, C_EOP, 1);
        repeat (8) @(negedge clk);
        check_out("post_rst");
        check("post_rst_drop", drop_count, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
